// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: sequences CPU/MMU memory requests onto the 8-bit shared board bus.
// Each byte of a 1..4-byte transfer gets a low/high address-latch phase on io_out,
// then a RAM or ROM access with chip enable and rd/wr strobe.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   address, read, write     request (level); only address[15:0] reach the bus
//   byte_count, wr_data      length minus one, little-endian write data
//   rd_data, rd_done         read data and its one-cycle valid pulse
//   wr_done, bus_err         write complete pulse; bus_err with it on a ROM write
//   busy                     transfer in progress
//   addr_le0, addr_le1       address-latch strobes (low / high byte)
//   ram_ce_n/rd_n/wr_n       RAM strobes, active-low
//   rom_ce_n/rd_n            ROM strobes, active-low
//   io_out, io_oe, io_in     shared bus drive value, drive enable, sample
//
// Build option: EXT_BUS_HI_SKIP_EN skips the high-byte latch phase when the
// external latch already holds the right value.
//
// All pins are registered: the FSM decodes its current state into *Nxt values,
// so pins follow the state by one cycle.
module ext_bus_ctrl #(
    parameter int unsigned STROBE_CYC  = 1,
    parameter int unsigned ACCESS_CYC  = 2,
    parameter int unsigned ROM_SEL_BIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  byte_count,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_done,
    output logic        wr_done,
    output logic        bus_err,
    output logic        busy,
    output logic        addr_le0,
    output logic        addr_le1,
    output logic        ram_ce_n,
    output logic        ram_rd_n,
    output logic        ram_wr_n,
    output logic        rom_ce_n,
    output logic        rom_rd_n,
    output logic [7:0]  io_out,
    output logic        io_oe,
    input  logic [7:0]  io_in
);

    localparam int unsigned MAX_CYC = (STROBE_CYC + 1 > ACCESS_CYC) ? STROBE_CYC + 1 : ACCESS_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAT_LO = 3'd1;
    localparam logic [2:0] LAT_HI = 3'd2;
    localparam logic [2:0] ACCESS = 3'd3;
    localparam logic [2:0] TURN   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] REARM  = 3'd6;

    logic [2:0]       state, stateNxt;
    logic [CNT_W-1:0] phase, phaseNxt;
    logic [15:0]      curAddr, curAddrNxt;
    logic [1:0]       byteIdx, byteIdxNxt;
    logic [1:0]       lastIdx, lastIdxNxt;
    logic [31:0]      wrBuf, wrBufNxt;
    logic             isWrite, isWriteNxt;
    logic             isRam, isRamNxt;
    logic             sampleQ, sampleNxt;
    logic [1:0]       sampleIdx, sampleIdxNxt;
    logic             hiSkip;

    logic [31:0] rdDataNxt;
    logic        rdDoneNxt, wrDoneNxt, busErrNxt, busyNxt;
    logic        le0Nxt, le1Nxt, ioOeNxt;
    logic [7:0]  ioOutNxt;
    logic        ramCeNxt, ramRdNxt, ramWrNxt, romCeNxt, romRdNxt;

    logic        unusedHiAddr;
    assign unusedHiAddr = ^address[23:16];

`ifdef EXT_BUS_HI_SKIP_EN
    // Mirror of the external high-byte latch contents.
    logic [7:0] lastHi, lastHiNxt;
    logic       hiValid, hiValidNxt;

    assign hiSkip = hiValid && (curAddr[15:8] == lastHi);

    always_comb begin
        lastHiNxt  = lastHi;
        hiValidNxt = hiValid;
        if (state == LAT_HI) begin
            lastHiNxt  = curAddr[15:8];
            hiValidNxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastHi  <= 8'h00;
            hiValid <= 1'b0;
        end else begin
            lastHi  <= lastHiNxt;
            hiValid <= hiValidNxt;
        end
    end
`else
    assign hiSkip = 1'b0;
`endif

    // Next-state, datapath and pin decode.
    always_comb begin
        stateNxt     = state;
        phaseNxt     = phase;
        curAddrNxt   = curAddr;
        byteIdxNxt   = byteIdx;
        lastIdxNxt   = lastIdx;
        wrBufNxt     = wrBuf;
        isWriteNxt   = isWrite;
        isRamNxt     = isRam;
        sampleNxt    = 1'b0;
        sampleIdxNxt = sampleIdx;
        rdDataNxt    = rd_data;
        rdDoneNxt    = 1'b0;
        wrDoneNxt    = 1'b0;
        busErrNxt    = 1'b0;
        busyNxt      = 1'b0;
        le0Nxt       = 1'b0;
        le1Nxt       = 1'b0;
        ioOeNxt      = 1'b0;
        ioOutNxt     = 8'h00;
        ramCeNxt     = 1'b1;
        ramRdNxt     = 1'b1;
        ramWrNxt     = 1'b1;
        romCeNxt     = 1'b1;
        romRdNxt     = 1'b1;

        // Read byte lands at the end of the pin-side last access cycle.
        if (sampleQ) begin
            rdDataNxt[{sampleIdx, 3'b000} +: 8] = io_in;
        end

        case (state)
            IDLE: begin
                if (read || write) begin
                    curAddrNxt = address[15:0];
                    lastIdxNxt = byte_count;
                    byteIdxNxt = 2'd0;
                    wrBufNxt   = wr_data;
                    isWriteNxt = write;
                    isRamNxt   = address[ROM_SEL_BIT];
                    phaseNxt   = '0;
                    rdDataNxt  = 32'h0;
                    // ROM is not writable: report the error without touching the bus.
                    stateNxt   = (write && !address[ROM_SEL_BIT]) ? DONE : LAT_LO;
                end
            end
            LAT_LO: begin
                busyNxt  = 1'b1;
                ioOeNxt  = 1'b1;
                ioOutNxt = curAddr[7:0];
                le0Nxt   = (phase < CNT_W'(STROBE_CYC));
                if (phase == CNT_W'(STROBE_CYC)) begin
                    phaseNxt = '0;
                    stateNxt = hiSkip ? ACCESS : LAT_HI;
                end else begin
                    phaseNxt = phase + CNT_W'(1);
                end
            end
            LAT_HI: begin
                busyNxt  = 1'b1;
                ioOeNxt  = 1'b1;
                ioOutNxt = curAddr[15:8];
                le1Nxt   = (phase < CNT_W'(STROBE_CYC));
                if (phase == CNT_W'(STROBE_CYC)) begin
                    phaseNxt = '0;
                    stateNxt = ACCESS;
                end else begin
                    phaseNxt = phase + CNT_W'(1);
                end
            end
            ACCESS: begin
                busyNxt      = 1'b1;
                ramCeNxt     = !isRam;
                romCeNxt     = isRam;
                sampleIdxNxt = byteIdx;
                if (isWrite) begin
                    ramWrNxt = 1'b0;
                    ioOeNxt  = 1'b1;
                    ioOutNxt = wrBuf[{byteIdx, 3'b000} +: 8];
                end else begin
                    ramRdNxt  = !isRam;
                    romRdNxt  = isRam;
                    sampleNxt = (phase == CNT_W'(ACCESS_CYC - 1));
                end
                if (phase == CNT_W'(ACCESS_CYC - 1)) begin
                    phaseNxt = '0;
                    if (byteIdx == lastIdx) begin
                        stateNxt = DONE;
                    end else begin
                        curAddrNxt = curAddr + 16'd1;
                        byteIdxNxt = byteIdx + 2'd1;
                        stateNxt   = isWrite ? LAT_LO : TURN;
                    end
                end else begin
                    phaseNxt = phase + CNT_W'(1);
                end
            end
            TURN: begin
                // Bus released for a cycle before we drive the next address.
                busyNxt  = 1'b1;
                stateNxt = LAT_LO;
            end
            DONE: begin
                busyNxt   = 1'b1;
                rdDoneNxt = !isWrite;
                wrDoneNxt = isWrite;
                busErrNxt = isWrite && !isRam;
                stateNxt  = REARM;
            end
            REARM: begin
                if (!read && !write) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // State, datapath and registered pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            curAddr   <= 16'h0;
            byteIdx   <= 2'd0;
            lastIdx   <= 2'd0;
            wrBuf     <= 32'h0;
            isWrite   <= 1'b0;
            isRam     <= 1'b0;
            sampleQ   <= 1'b0;
            sampleIdx <= 2'd0;
            rd_data   <= 32'h0;
            rd_done   <= 1'b0;
            wr_done   <= 1'b0;
            bus_err   <= 1'b0;
            busy      <= 1'b0;
            addr_le0  <= 1'b0;
            addr_le1  <= 1'b0;
            io_oe     <= 1'b0;
            io_out    <= 8'h00;
            ram_ce_n  <= 1'b1;
            ram_rd_n  <= 1'b1;
            ram_wr_n  <= 1'b1;
            rom_ce_n  <= 1'b1;
            rom_rd_n  <= 1'b1;
        end else begin
            state     <= stateNxt;
            phase     <= phaseNxt;
            curAddr   <= curAddrNxt;
            byteIdx   <= byteIdxNxt;
            lastIdx   <= lastIdxNxt;
            wrBuf     <= wrBufNxt;
            isWrite   <= isWriteNxt;
            isRam     <= isRamNxt;
            sampleQ   <= sampleNxt;
            sampleIdx <= sampleIdxNxt;
            rd_data   <= rdDataNxt;
            rd_done   <= rdDoneNxt;
            wr_done   <= wrDoneNxt;
            bus_err   <= busErrNxt;
            busy      <= busyNxt;
            addr_le0  <= le0Nxt;
            addr_le1  <= le1Nxt;
            io_oe     <= ioOeNxt;
            io_out    <= ioOutNxt;
            ram_ce_n  <= ramCeNxt;
            ram_rd_n  <= ramRdNxt;
            ram_wr_n  <= ramWrNxt;
            rom_ce_n  <= romCeNxt;
            rom_rd_n  <= romRdNxt;
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl: table of transfers plus hand sequences (held request, reset
// mid-access). A bus monitor models the two external address latches and a
// memory that answers reads; expected bus cycles are queued when a transfer is
// driven and popped as the DUT strobes them.
module tb_ext_bus_ctrl;

    localparam int unsigned NV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] address;
    logic        read, write;
    logic [1:0]  byte_count;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_done, wr_done, bus_err, busy;
    logic        addr_le0, addr_le1;
    logic        ram_ce_n, ram_rd_n, ram_wr_n, rom_ce_n, rom_rd_n;
    logic [7:0]  io_out;
    logic        io_oe;
    logic [7:0]  io_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  bc;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic        ram;
        logic        wr;
        logic [7:0]  d;
    } exp_t;

    vec_t vecs [NV];
    exp_t expQ [$];

    logic [7:0] latLo = 8'h00;
    logic [7:0] latHi = 8'h00;
    int         le0Cnt = 0;
    int         le1Cnt = 0;
    logic       prevStb = 1'b0;
    logic       prevRead = 1'b0;
    logic       rdStb;

`ifdef EXT_BUS_HI_SKIP_EN
    logic [7:0] tbLastHi = 8'h00;
    logic       tbHv = 1'b0;
`endif

    always #5 clk = ~clk;

    ext_bus_ctrl dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .byte_count(byte_count), .wr_data(wr_data), .rd_data(rd_data),
        .rd_done(rd_done), .wr_done(wr_done), .bus_err(bus_err), .busy(busy),
        .addr_le0(addr_le0), .addr_le1(addr_le1),
        .ram_ce_n(ram_ce_n), .ram_rd_n(ram_rd_n), .ram_wr_n(ram_wr_n),
        .rom_ce_n(rom_ce_n), .rom_rd_n(rom_rd_n),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    function automatic logic [7:0] memByte(input logic [15:0] a);
        logic [7:0] t;
        t = 8'(a[7:0] * 3);
        return 8'(t + a[15:8]) ^ 8'h93;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end
    endfunction

    assign rdStb = !ram_rd_n || !rom_rd_n;
    assign io_in = rdStb ? memByte({latHi, latLo}) : 8'h00;

    // Bus monitor: external latches, scoreboard pop, turnaround check.
    always @(negedge clk) begin
        exp_t e;
        logic stb;
        if (rst) begin
            prevStb  = 1'b0;
            prevRead = 1'b0;
        end else begin
            if (addr_le0) begin le0Cnt++; latLo = io_out; end
            if (addr_le1) begin le1Cnt++; latHi = io_out; end
            stb = rdStb || !ram_wr_n;
            if (stb && !prevStb) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual_addr=%h required=none", {latHi, latLo});
                end else begin
                    e = expQ.pop_front();
                    chk("sb_addr", 32'({latHi, latLo}), 32'(e.a));
                    chk("sb_region", 32'({!ram_ce_n, !rom_ce_n}), e.ram ? 32'd2 : 32'd1);
                    chk("sb_op", 32'({!ram_wr_n, rdStb}), e.wr ? 32'd2 : 32'd1);
                    chk("sb_oe", 32'(io_oe), 32'(e.wr));
                    if (e.wr) chk("sb_wdata", 32'(io_out), 32'(e.d));
                end
            end
            if (!stb && prevStb && prevRead)
                chk("turn_idle", 32'({io_oe, addr_le0, addr_le1}), 32'd0);
            prevStb  = stb;
            prevRead = rdStb;
        end
    end

    // Drives one transfer and checks its outcome; drop releases the request after done.
    task automatic doXfer(input vec_t v, input logic drop);
        int          nb, lat, hiCnt, cyc;
        logic        isW, ram, hi;
        logic [15:0] a;
        nb    = int'(v.bc) + 1;
        isW   = v.wr;
        ram   = v.addr[15];
        lat   = 1;
        hiCnt = 0;
        if (!(isW && !ram)) begin
            for (int j = 0; j < nb; j++) begin
                a = 16'(v.addr[15:0] + 16'(j));
                expQ.push_back('{a: a, ram: ram, wr: isW,
                                 d: isW ? v.wdata[8*j +: 8] : memByte(a)});
                hi = 1'b1;
`ifdef EXT_BUS_HI_SKIP_EN
                if (tbHv && a[15:8] == tbLastHi) hi = 1'b0;
                if (hi) begin tbLastHi = a[15:8]; tbHv = 1'b1; end
`endif
                if (hi) hiCnt++;
                lat += 4 + (hi ? 2 : 0) + ((!isW && j < nb - 1) ? 1 : 0);
            end
        end else begin
            nb = 0;
        end
        le0Cnt     = 0;
        le1Cnt     = 0;
        address    = v.addr;
        read       = v.rd;
        write      = v.wr;
        byte_count = v.bc;
        wr_data    = v.wdata;
        @(posedge clk);
        #1;
        address    = ~v.addr;
        wr_data    = ~v.wdata;
        byte_count = ~v.bc;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) chk("busy_on", 32'(busy), 32'd1);
        end while (!(rd_done || wr_done) && cyc < 200);
        chk("latency", 32'(cyc), 32'(lat));
        chk("done_kind", 32'({rd_done, wr_done}), isW ? 32'd1 : 32'd2);
        chk("bus_err", 32'(bus_err), 32'(v.expErr));
        if (!isW) chk("rd_data", rd_data, v.expRd);
        chk("le0_cycles", 32'(le0Cnt), 32'(nb));
        chk("le1_cycles", 32'(le1Cnt), 32'(hiCnt));
        chk("sb_drained", 32'(expQ.size()), 32'd0);
        expQ.delete();
        if (drop) begin
            read  = 1'b0;
            write = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", 32'({rd_done, wr_done, bus_err}), 32'd0);
            @(negedge clk);
            chk("busy_off", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vec_t rv;
        vecs[0] = '{24'h000012, 1'b1, 1'b0, 2'd0, 32'h0,        32'h000000A5, 1'b0};
        vecs[1] = '{24'h0080FE, 1'b0, 1'b1, 2'd3, 32'h44332211, 32'h0,        1'b0};
        vecs[2] = '{24'h00FFFF, 1'b1, 1'b0, 2'd1, 32'h0,        32'h0000936F, 1'b0};
        vecs[3] = '{24'h000100, 1'b0, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0,        1'b1};
        vecs[4] = '{24'h00C003, 1'b1, 1'b1, 2'd1, 32'h0000BBAA, 32'h0,        1'b0};
        vecs[5] = '{24'h123456, 1'b1, 1'b0, 2'd2, 32'h0,        32'h00AFAAA5, 1'b0};
        vecs[6] = '{24'h00FFFE, 1'b1, 1'b0, 2'd3, 32'h0,        32'h90936F6A, 1'b0};
        vecs[7] = '{24'h00FFFF, 1'b0, 1'b1, 2'd0, 32'h00000077, 32'h0,        1'b0};

        rst = 1'b1; read = 1'b0; write = 1'b0;
        address = 24'h0; byte_count = 2'd0; wr_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_n_pins", 32'({ram_ce_n, ram_rd_n, ram_wr_n, rom_ce_n, rom_rd_n}), 32'h1F);
        chk("rst_misc", 32'({addr_le0, addr_le1, io_oe, rd_done, wr_done, bus_err, busy}), 32'h0);
        chk("rst_io_out", 32'(io_out), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < int'(NV); i++) doXfer(vecs[i], 1'b1);

        // Held read: no re-accept until read drops for one cycle.
        doXfer(vecs[0], 1'b0);
        le0Cnt = 0;
        repeat (6) @(negedge clk);
        chk("hold_no_relatch", 32'(le0Cnt), 32'd0);
        chk("hold_busy", 32'(busy), 32'd0);
        read = 1'b0;
        @(negedge clk);
        doXfer(vecs[0], 1'b1);

        // Reset during the access of a RAM write.
        rv = '{24'h008000, 1'b0, 1'b1, 2'd0, 32'h0000005A, 32'h0, 1'b0};
        expQ.push_back('{a: 16'h8000, ram: 1'b1, wr: 1'b1, d: 8'h5A});
        address = rv.addr; write = 1'b1; byte_count = rv.bc; wr_data = rv.wdata;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ram_wr_n && cyc < 50);
        chk("rst_test_reached_access", 32'(ram_wr_n), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_strobes", 32'({ram_ce_n, ram_wr_n, io_oe, busy}), 32'hC);
        write = 1'b0;
        expQ.delete();
`ifdef EXT_BUS_HI_SKIP_EN
        tbHv = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_held_quiet", 32'({addr_le0, addr_le1, ram_ce_n, rom_ce_n}), 32'h3);
        rst = 1'b0;
        @(negedge clk);
        doXfer(vecs[2], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
